// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// mult/multu use shift-add and div/divu use restoring division, one bit per
// cycle. Every operation takes WIDTH+1 cycles, including divide by zero.
// Optional feature: define MULDIV_SIGNED_EN to enable signed mult/div.
// When it is undefined, op[0] is ignored and all operations are unsigned.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic                 busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   acc_r;      // multiply: {partial, multiplier}; divide: {rem, quot}
  logic [WIDTH-1:0]     opnd_r;     // multiplicand or divisor magnitude
  logic                 is_div_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       mul_sum_s, div_trial_s;
  logic [2*WIDTH-1:0]   mul_next_s, div_next_s;
  logic [WIDTH-1:0]     res_hi_s, res_lo_s;

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation at double width.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

`ifdef MULDIV_SIGNED_EN
  logic a_neg_s, b_neg_s;
  logic neg_q_r, neg_rem_r, div0_r;
  assign a_neg_s = op[0] & a[WIDTH-1];
  assign b_neg_s = op[0] & b[WIDTH-1];
  assign a_mag_s = a_neg_s ? neg_w(a) : a;
  assign b_mag_s = b_neg_s ? neg_w(b) : b;
`else
  logic unused_op0_s;
  assign unused_op0_s = op[0];
  assign a_mag_s      = a;
  assign b_mag_s      = b;
`endif

  // One shift-add step and one restoring-division step, chosen later by op.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
    if (div_trial_s[WIDTH]) begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  // Final sign correction of the magnitude result written at FINISH.
  always_comb begin
    res_hi_s = acc_r[2*WIDTH-1:WIDTH];
    res_lo_s = acc_r[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (is_div_r) begin
      // Divide by zero keeps the all-ones quotient regardless of signs.
      if (neg_q_r && !div0_r) begin
        res_lo_s = neg_w(acc_r[WIDTH-1:0]);
      end else begin
        res_lo_s = acc_r[WIDTH-1:0];
      end
      if (neg_rem_r) begin
        res_hi_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
      end else begin
        res_hi_s = acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (neg_q_r) begin
        {res_hi_s, res_lo_s} = neg_2w(acc_r);
      end else begin
        {res_hi_s, res_lo_s} = acc_r;
      end
    end
`endif
  end

  // Next-state and registered-output decode for the control FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CW'(1)) state_nxt_s = FINISH;
        else                 state_nxt_s = RUN;
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_r == FINISH);
  end

  // Control state, busy and done registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Datapath: operand capture, iteration, and HI/LO updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
`ifdef MULDIV_SIGNED_EN
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (hi_we) hi_r <= wdata;
          if (lo_we) lo_r <= wdata;
          if (start) begin
            cnt_r    <= CW'(WIDTH);
            is_div_r <= op[1];
            if (op[1]) begin
              acc_r  <= {{WIDTH{1'b0}}, a_mag_s};
              opnd_r <= b_mag_s;
            end else begin
              acc_r  <= {{WIDTH{1'b0}}, b_mag_s};
              opnd_r <= a_mag_s;
            end
`ifdef MULDIV_SIGNED_EN
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            div0_r    <= (b == {WIDTH{1'b0}});
`endif
          end
        end
        RUN: begin
          cnt_r <= cnt_r - CW'(1);
          acc_r <= is_div_r ? div_next_s : mul_next_s;
        end
        FINISH: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Expected HI/LO come from a
// 64-bit arithmetic model pushed to a scoreboard at start, popped at done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_vec = 0;
  int           n_err = 0;
  logic [63:0]  exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic   sgn;
    longint sx, sy;
    logic [31:0] q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    if (!o[1]) return 64'(sx * sy);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    q = 32'(sx / sy);
    r = 32'(sx % sy);
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string tag, input bit disturb);
    int cyc = 0;
    int bcnt = 0;
    logic [63:0] e;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bcnt++;
      if (disturb && cyc == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        a = $urandom; b = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, " done"},    64'(done), 64'd1);
    check({tag, " latency"}, 64'(cyc),  64'd33);
    check({tag, " busy_cyc"}, 64'(bcnt), 64'd33);
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = {64{1'bx}};
    check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
  endtask

  initial begin
    int dn;
    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi",   64'(hi),   64'd0);
    check("rst lo",   64'(lo),   64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Direct HI/LO writes in IDLE.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi lo", 64'(lo), 64'd0);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo lo", 64'(lo), 64'hCAFE_F00D);
    check("mtlo hi", 64'(hi), 64'h1234_5678);

    // Directed operations, issued back-to-back in the done cycle.
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("multu_max", 1'b0);
    start_op(2'b01, 32'hFFFF_FFFD, 32'd5);         wait_done("mult_neg", 1'b0);
    start_op(2'b11, 32'hFFFF_FFF9, 32'd2);         wait_done("div_neg", 1'b0);
    start_op(2'b10, 32'd100, 32'd7);               wait_done("divu", 1'b0);
    start_op(2'b10, 32'd100, 32'd0);               wait_done("divu_zero", 1'b0);
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", 1'b0);
    start_op(2'b11, 32'hFFFF_FFF9, 32'd0);         wait_done("div_zero_neg", 1'b0);
    @(negedge clk);
    check("done width", 64'(done), 64'd0);

    // start, writes and operand changes during RUN are ignored.
    start_op(2'b00, 32'h0001_2345, 32'h0000_6789); wait_done("run_ignore", 1'b1);
    @(negedge clk);
    check("no_queued busy", 64'(busy), 64'd0);

    // Write on the start edge lands immediately, result overwrites at FINISH.
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    start_op(2'b10, 32'd1000, 32'd33);
    hi_we = 1'b0;
    check("same_edge hi", 64'(hi), 64'hAAAA_5555);
    wait_done("same_edge", 1'b0);

    // Random operations.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rb;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      start_op(2'($urandom), $urandom, rb);
      wait_done("rand", 1'b0);
    end

    // Reset mid-operation aborts and clears.
    start_op(2'b00, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi",   64'(hi),   64'd0);
    check("abort lo",   64'(lo),   64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) dn++;
    end
    check("abort no_done", 64'(dn), 64'd0);
    check("abort hi_hold", 64'(hi), 64'd0);
    start_op(2'b00, 32'd7, 32'd6); wait_done("after_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
